// File: rtl/block_ram_pipe.sv
// Single-port-pair block RAM with byte-enable writes, a LATENCY-deep read pipeline
// and a clear engine that zeros one word per clock.
module block_ram_pipe #(
  parameter int unsigned ABITS          = 9,
  parameter int unsigned DBITS          = 64,
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned WR_MODE        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [DBITS-1:0]   w_data,
  input  logic [DBITS/8-1:0] w_be,
  input  logic               w_valid,
  input  logic [ABITS-1:0]   w_addr,
  input  logic               r_en,
  input  logic [ABITS-1:0]   r_addr,
  output logic [DBITS-1:0]   r_data,
  output logic               r_valid,
  input  logic               clear,
  output logic               ready
);

  localparam int unsigned DEPTH  = 2**ABITS;
  localparam int unsigned NBYTES = DBITS/8;

  typedef enum logic {IDLE, CLEAR} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  state_t             state_q, state_d;
  logic [ABITS-1:0]   cnt_q, cnt_d;
  logic               ready_q;

  logic [DBITS-1:0]   mem [DEPTH];
  logic [DBITS-1:0]   pipe_q [LATENCY];
  logic [LATENCY-1:0] vld_q;
  logic [DBITS-1:0]   r_data_q;
  logic               r_valid_q;

  logic               wr_en, rd_en;
  logic [DBITS-1:0]   rd_word;

  assign wr_en = ready_q && w_valid;
  assign rd_en = ready_q && r_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (&cnt_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ready is registered from the next state so it is already low during reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
    end
  end

  always_comb begin
    rd_word = mem[r_addr];
    if (WR_MODE != 0 && wr_en && (w_addr == r_addr)) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (w_be[b]) rd_word[8*b +: 8] = w_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (w_be[b]) mem[w_addr][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
    pipe_q[0] <= rd_word;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q     <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      vld_q[0] <= rd_en;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      r_valid_q <= vld_q[LATENCY-1];
      if (vld_q[LATENCY-1]) r_data_q <= pipe_q[LATENCY-1];
    end
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
  assign ready   = ready_q;

endmodule
